// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit (package fetch_pkg).
// Optional fetch counter is enabled by defining INSTR_FETCH_PERF_CNT_EN.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int          OPCODE_W  = 7;

  typedef enum logic {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } fetch_state_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Bus bundle of the fetch unit: memory request/response, redirect and decode sides.
// master = fetch unit, slave = surrounding pipeline/memory.
interface instr_fetch_if;
  import fetch_pkg::*;

  logic                imem_req_valid;
  logic                imem_req_ready;
  logic [31:0]         imem_req_addr;
  logic                imem_rsp_valid;
  logic [31:0]         imem_rsp_data;
  logic                redirect_valid;
  logic [31:0]         redirect_pc;
  logic                id_valid;
  logic                id_ready;
  logic [31:0]         id_instr;
  logic [31:0]         id_pc;
  logic [OPCODE_W-1:0] id_opcode;
  logic [31:0]         fetch_count;

  modport master (
    output imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, id_opcode, fetch_count,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, id_opcode, fetch_count,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, id_ready
  );

endinterface

// File: rtl/instr_fetch_fifo.sv
// DEPTH-entry synchronous FIFO of {pc, instr} words with clear; head is read combinationally
// so a pushed entry is visible to decode exactly one cycle later.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  input  logic             clear_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o && !clear_i;
  assign do_push = push_i && (!full_o || do_pop) && !clear_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count/pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues in-order word fetches, buffers responses for decode and
// flushes stale responses after a redirect. Counter built only with INSTR_FETCH_PERF_CNT_EN.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input logic           clk,
  input logic           reset,
  instr_fetch_if.master bus
);

  localparam int unsigned CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

  fetch_state_t  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   occupancy;
  logic [63:0]   fifo_head;
  logic          fifo_empty, fifo_full;
  logic          req_valid, req_fire, rsp_taken, push, pop;
  logic [31:0]   target_pc, instr_out;

  assign target_pc = align_pc(bus.redirect_pc);
  assign occupancy = {1'b0, outstanding_q} + {1'b0, fifo_count};
  assign req_fire  = req_valid && bus.imem_req_ready;
  // Responses always retire an outstanding slot, even when their data is dropped.
  assign rsp_taken = bus.imem_rsp_valid && (outstanding_q != '0);
  assign push      = rsp_taken && (state_q == FETCH) && !bus.redirect_valid && (!fifo_full || pop);
  assign pop       = bus.id_valid && bus.id_ready;
  assign outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_taken);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH: if (bus.redirect_valid && (outstanding_d != '0)) state_d = FLUSH;
      FLUSH: if (!bus.redirect_valid && (outstanding_d == '0)) state_d = FETCH;
    endcase
  end

  always_comb begin
    req_valid          = reset && (state_q == FETCH) && !bus.redirect_valid && (occupancy < DEPTH_L);
    instr_out          = fifo_empty ? NOP_INSTR : fifo_head[31:0];
    bus.imem_req_valid = req_valid;
    bus.imem_req_addr  = fetch_pc_q;
    bus.id_valid       = !fifo_empty && !bus.redirect_valid;
    bus.id_instr       = instr_out;
    bus.id_pc          = fifo_empty ? resp_pc_q : fifo_head[63:32];
    bus.id_opcode      = instr_out[OPCODE_W-1:0];
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    if (bus.redirect_valid) begin
      fetch_pc_d = target_pc;
      resp_pc_d  = target_pc;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      if (push)     resp_pc_d  = resp_pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i ({resp_pc_q, bus.imem_rsp_data}),
    .pop_i       (pop),
    .clear_i     (bus.redirect_valid),
    .head_o      (fifo_head),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .count_o     (fifo_count)
  );

`ifdef INSTR_FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   fetch_count_q <= '0;
    else if (pop) fetch_count_q <= fetch_count_q + 32'd1;
  end

  assign bus.fetch_count = fetch_count_q;
`else
  assign bus.fetch_count = 32'h0;
`endif

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter DEPTH, default 2: maximum in-flight plus buffered instructions; legal values are 2 and 4.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 imem_req_valid  output  1  fetch request valid.
REQ-006 imem_req_ready  input  1  memory accepts request.
REQ-007 imem_req_addr  output  32  word-aligned fetch address.
REQ-008 imem_rsp_valid  input  1  instruction word returned, in request order.
REQ-009 imem_rsp_data  input  32  returned instruction word.
REQ-010 redirect_valid  input  1  branch/jump taken; restart fetch.
REQ-011 redirect_pc  input  32  restart target, bits [1:0] ignored (treated 0).
REQ-012 id_valid  output  1  instruction available to decode.
REQ-013 id_ready  input  1  decode accepts instruction.
REQ-014 id_instr  output  32  instruction to decode.
REQ-015 id_pc  output  32  address of id_instr.
REQ-016 id_opcode  output  7  id_instr[6:0]; drives the decode controller Opcode input.
REQ-017 fetch_count  output  32  accepted-instruction counter (see Configuration).

Function
REQ-018 FSM states: FETCH, FLUSH; reset state FETCH.
REQ-019 Request issue: imem_req_valid = (state==FETCH) && !redirect_valid && (outstanding + buffered < DEPTH).
REQ-020 On request handshake (valid && ready), fetch PC += 4, outstanding += 1; wraps modulo 2^32.
REQ-021 On response in FETCH: write {resp_pc, imem_rsp_data} into buffer; resp_pc += 4; outstanding -= 1.
REQ-022 Response with outstanding==0 is ignored (protocol error; bench asserts it never occurs).
REQ-023 Decode handshake: id_valid = buffer non-empty && !redirect_valid; transfer when id_valid && id_ready; pops one entry.
REQ-024 Buffer empty: id_instr = 32'h0000_0013 (NOP), id_pc = resp_pc.
REQ-025 Zero-latency bypass not required: response-to-id_valid latency is exactly 1 cycle.
REQ-026 Simultaneous push and pop in same cycle are both honoured; occupancy unchanged.
REQ-027 Redirect has priority over all same-cycle events: no request issued, response discarded, no decode transfer, buffer cleared, fetch PC and resp_pc <= redirect_pc.
REQ-028 Redirect with outstanding (after same-cycle request/response accounting) > 0 -> FLUSH; otherwise remain FETCH.
REQ-029 In FLUSH: responses discarded, outstanding -= 1 each; no requests; return to FETCH the cycle after outstanding reaches 0.
REQ-030 Redirect while in FLUSH: reloads PCs, stays in FLUSH.

Reset
REQ-031 Reset asserted: state FETCH, fetch PC = resp_pc = RESET_PC, outstanding 0, buffer empty, fetch_count 0.
REQ-032 Outputs during reset: imem_req_valid 0, imem_req_addr RESET_PC, id_valid 0, id_instr NOP, id_pc RESET_PC, id_opcode 7'b0010011.
REQ-033 Reset mid-operation discards all in-flight responses; memory is reset by the same signal.

Configuration
REQ-034 Macro INSTR_FETCH_PERF_CNT_EN defined: fetch_count increments by 1 per decode handshake, wraps at 2^32.
REQ-035 Macro undefined: counter not built; fetch_count tied to 32'h0.

Structure
REQ-036 Package fetch_pkg holds: NOP_INSTR constant, OPCODE_W=7, fetch_state_t enum {FETCH, FLUSH}.
REQ-037 Sub-module fetch_fifo: DEPTH-entry 64-bit ({pc, instr}) synchronous FIFO with push, pop, empty, full, clear.

Verification
REQ-038 Reset release, memory always ready, 1-cycle response, id_ready=1 -> id_pc sequence 0,4,8,12; id_instr equals memory contents.
REQ-039 id_ready=0 for 10 cycles -> at most DEPTH requests issued, imem_req_valid low thereafter, no instruction lost after release.
REQ-040 Redirect to 0x100 with 2 outstanding -> FLUSH, both stale responses dropped, next id_pc = 0x100.
REQ-041 Redirect in same cycle as response and id_ready=1 -> no decode transfer that cycle, response discarded, buffer empty.
REQ-042 redirect_pc=0xFFFF_FFFC -> id_pc 0xFFFF_FFFC then 0x0000_0000.
REQ-043 With INSTR_FETCH_PERF_CNT_EN, 5 accepted instructions -> fetch_count=5; without it fetch_count=0.
